upgrade_spawner: RTL and testbench
==================================

Name: upgrade_spawner

Overview:
- Upstream stage of upgrade_armor. Decides when and where the armor upgrade pickup appears on the 640x480 playfield, and drives UpgradeX/UpgradeY/Upgrade_Size into it.
- Consumes upgrade_armor's was_collected level to retire the pickup.
- Picks spawn positions with a free-running LFSR and rejects spots overlapping either player.
- Relocates the pickup if it is not collected within a lifetime window.

Parameters:
- SPAWN_DELAY, 120, frames spent in WAIT before a placement attempt.
- LIFETIME, 600, frames the pickup stays visible before relocating.
- UPGRADE_SIZE, 4, half-size of the pickup, driven on Upgrade_Size.
- X_MIN, 32 / X_MAX, 607, legal spawn-centre X range, inclusive.
- Y_MIN, 32 / Y_MAX, 447, legal spawn-centre Y range, inclusive.
- MARGIN, 8, extra clearance between a player and the spawn point.
- MAX_TRIES, 16, rejected candidates before the fallback position is used.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.
- PARK_X, 1000 / PARK_Y, 1000, off-field position used whenever the pickup is hidden.

Ports:
- Reset  in  1  asynchronous, active-high
- frame_clk  in  1  clock; one edge per video frame
- BallX, BallY  in  10  P1 centre
- Ball2X, Ball2Y  in  10  P2 centre
- Ball_Size  in  10  player half-size
- was_collected  in  1  level from upgrade_armor
- UpgradeX, UpgradeY  out  10  pickup centre
- Upgrade_Size  out  10  pickup half-size
- upgrade_visible  out  1  high while the pickup is drawn and collectable

Behaviour:
- Reset:
  - state=WAIT, timer=0, tries=0, lfsr=LFSR_SEED, collected_q=0.
  - UpgradeX=PARK_X, UpgradeY=PARK_Y, upgrade_visible=0.
  - Upgrade_Size=UPGRADE_SIZE, constant at all times.
  - Reset is honoured mid-operation in any state.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11; left shift, feedback into bit 0.
  - Advances on every frame_clk edge regardless of state.
- Hidden states (all except ACTIVE):
  - Outputs stay parked at PARK_X/PARK_Y.
  - This keeps upgrade_armor's box test unsatisfiable, because both balls are always under 640.
- Collection detection:
  - collected_q <= was_collected.
  - collect_edge = was_collected & ~collected_q.
  - Any state with was_collected=1 goes to COLLECTED on the next edge. This has priority over every other transition.
- WAIT:
  - timer increments each frame.
  - At timer==SPAWN_DELAY-1: timer<=0, tries<=0, go to PICK.
- PICK (one candidate per frame):
  - candX = X_MIN + lfsr[8:0], candY = Y_MIN + lfsr[15:8]. Both are 10-bit; overflow is impossible with the defaults.
  - Reject if candX>X_MAX or candY>Y_MAX.
  - Reject if, for either player, |candX-BX| <= Ball_Size+UPGRADE_SIZE+MARGIN and |candY-BY| <= the same sum. Absolute differences use unsigned compare-then-subtract.
  - On accept: latch candX/candY onto UpgradeX/UpgradeY, set upgrade_visible=1, timer<=0, go to ACTIVE. All of this takes effect on the same edge.
  - On reject: tries++.
  - If the rejecting candidate makes tries reach MAX_TRIES: use the fallback (320,240), unconditionally visible, then go to ACTIVE.
- ACTIVE:
  - Position is held constant and timer increments.
  - At timer==LIFETIME-1 with no collect: park, upgrade_visible=0, timer<=0, go to WAIT (respawn elsewhere).
  - Timeout and collect_edge on the same edge: COLLECTED wins.
- COLLECTED:
  - Terminal until Reset.
  - Outputs parked, upgrade_visible=0.
  - upgrade_armor owns the armor from this point on.
- Latency: upgrade_armor raises was_collected at frame edge k; this block parks and drops upgrade_visible at edge k+1.

Decomposition:
- Shared package upgrade_pkg:
  - state enum (WAIT, PICK, ACTIVE, COLLECTED).
  - Screen constants SCREEN_W=640 and SCREEN_H=480.
  - PARK_X/PARK_Y defaults.
  - Direction codes 00 L, 01 R, 10 D, 11 U, already used by the armor logic.
- Sub-module lfsr16 (seed parameter; outputs the 16-bit value; always enabled). It is natural to factor out because future pickups reuse it.
- Overlap check stays inline as a function.

Test Plan:
1. Reset held 3 frames, then released, with SPAWN_DELAY=4. Required: outputs at (1000,1000) with visible=0 during reset and WAIT; exactly 4 frames after release the block is in PICK; visible rises on the first accepted candidate.
2. Both balls at (10,10), Ball_Size=8. Required: the first accepted position equals the value predicted by the LFSR model from seed 16'hACE1; visible=1; position holds for LIFETIME frames.
3. LIFETIME=8, no collection. Required: visible drops after 8 ACTIVE frames; outputs park; a new spawn occurs after SPAWN_DELAY frames at a different LFSR-derived position.
4. was_collected rises 3 frames into ACTIVE. Required: on the next edge visible=0, outputs at (1000,1000), state COLLECTED; nothing changes over 1000 further frames.
5. Both players placed over the whole legal field, forcing every candidate to be rejected. Required: after 16 rejects the pickup appears at (320,240) with visible=1.
6. Collect on the same edge as LIFETIME expiry. Required: COLLECTED, not WAIT. Then Reset asserted mid-COLLECTED. Required: immediate asynchronous park and WAIT; the LFSR reload reproduces scenario 2's first position.

Source files
------------

// File: rtl/upgrade_pkg.sv
// rtl/upgrade_pkg.sv - shared constants and types for the upgrade pickup blocks
package upgrade_pkg;
    typedef enum logic [1:0] {
        ST_WAIT      = 2'd0,
        ST_PICK      = 2'd1,
        ST_ACTIVE    = 2'd2,
        ST_COLLECTED = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        DIR_L = 2'b00,
        DIR_R = 2'b01,
        DIR_D = 2'b10,
        DIR_U = 2'b11
    } dir_t;

    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int PARK_X_DEF = 1000;
    localparam int PARK_Y_DEF = 1000;
endpackage

// File: rtl/upgrade_spawner_if.sv
// rtl/upgrade_spawner_if.sv - player positions in, pickup placement out
interface upgrade_spawner_if;
    logic [9:0] BallX;
    logic [9:0] BallY;
    logic [9:0] Ball2X;
    logic [9:0] Ball2Y;
    logic [9:0] Ball_Size;
    logic       was_collected;
    logic [9:0] UpgradeX;
    logic [9:0] UpgradeY;
    logic [9:0] Upgrade_Size;
    logic       upgrade_visible;

    modport master (
        input  BallX, BallY, Ball2X, Ball2Y, Ball_Size, was_collected,
        output UpgradeX, UpgradeY, Upgrade_Size, upgrade_visible
    );

    modport slave (
        output BallX, BallY, Ball2X, Ball2Y, Ball_Size, was_collected,
        input  UpgradeX, UpgradeY, Upgrade_Size, upgrade_visible
    );
endinterface

// File: rtl/upgrade_spawner_lfsr16.sv
// rtl/upgrade_spawner_lfsr16.sv - free-running 16-bit Fibonacci LFSR (taps 16,14,13,11)
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        frame_clk,
    input  logic        Reset,
    output logic [15:0] value
);
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            value <= SEED;
        end else begin
            value <= {value[14:0], value[15] ^ value[13] ^ value[12] ^ value[10]};
        end
    end
endmodule

// File: rtl/upgrade_spawner.sv
// rtl/upgrade_spawner.sv - places the armor pickup at LFSR-chosen spots clear of both players
module upgrade_spawner
    import upgrade_pkg::*;
#(
    parameter int          SPAWN_DELAY  = 120,
    parameter int          LIFETIME     = 600,
    parameter int          UPGRADE_SIZE = 4,
    parameter int          X_MIN        = 32,
    parameter int          X_MAX        = 607,
    parameter int          Y_MIN        = 32,
    parameter int          Y_MAX        = 447,
    parameter int          MARGIN       = 8,
    parameter int          MAX_TRIES    = 16,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int          PARK_X       = PARK_X_DEF,
    parameter int          PARK_Y       = PARK_Y_DEF
) (
    input  logic               frame_clk,
    input  logic               Reset,
    upgrade_spawner_if.master  bus
);
    localparam logic [1:0] S_WAIT      = ST_WAIT;
    localparam logic [1:0] S_PICK      = ST_PICK;
    localparam logic [1:0] S_ACTIVE    = ST_ACTIVE;
    localparam logic [1:0] S_COLLECTED = ST_COLLECTED;

    localparam int TMAX = (SPAWN_DELAY > LIFETIME) ? SPAWN_DELAY : LIFETIME;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int RW   = $clog2(MAX_TRIES + 1);

    logic [1:0]    state;
    logic [TW-1:0] timer;
    logic [RW-1:0] tries;
    logic          collected_q;
    logic [9:0]    up_x;
    logic [9:0]    up_y;
    logic          visible;
    logic [15:0]   lfsr;
    logic [9:0]    cand_x;
    logic [9:0]    cand_y;
    logic [10:0]   reach;
    logic          accept;
    logic          collect_edge;
    logic          go_collect;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .value     (lfsr)
    );

    function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    function automatic logic near(input logic [9:0] cx, input logic [9:0] cy,
                                  input logic [9:0] bx, input logic [9:0] by,
                                  input logic [10:0] r);
        return ({1'b0, abs_diff(cx, bx)} <= r) && ({1'b0, abs_diff(cy, by)} <= r);
    endfunction

    assign cand_x = 10'(X_MIN) + {1'b0, lfsr[8:0]};
    assign cand_y = 10'(Y_MIN) + {2'b00, lfsr[15:8]};
    assign reach  = {1'b0, bus.Ball_Size} + 11'(UPGRADE_SIZE + MARGIN);
    assign accept = (cand_x <= 10'(X_MAX)) && (cand_y <= 10'(Y_MAX))
                 && !near(cand_x, cand_y, bus.BallX, bus.BallY, reach)
                 && !near(cand_x, cand_y, bus.Ball2X, bus.Ball2Y, reach);

    // A fresh rising edge or a level still held both retire the pickup.
    assign collect_edge = bus.was_collected & ~collected_q;
    assign go_collect   = collect_edge | (bus.was_collected & collected_q);

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state       <= S_WAIT;
            timer       <= '0;
            tries       <= '0;
            collected_q <= 1'b0;
            up_x        <= 10'(PARK_X);
            up_y        <= 10'(PARK_Y);
            visible     <= 1'b0;
        end else begin
            collected_q <= bus.was_collected;
            if (go_collect) begin
                state   <= S_COLLECTED;
                up_x    <= 10'(PARK_X);
                up_y    <= 10'(PARK_Y);
                visible <= 1'b0;
            end else begin
                case (state)
                    S_WAIT: begin
                        if (timer == TW'(SPAWN_DELAY - 1)) begin
                            timer <= '0;
                            tries <= '0;
                            state <= S_PICK;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    S_PICK: begin
                        if (accept) begin
                            up_x    <= cand_x;
                            up_y    <= cand_y;
                            visible <= 1'b1;
                            timer   <= '0;
                            state   <= S_ACTIVE;
                        end else begin
                            tries <= tries + 1'b1;
                            if (tries == RW'(MAX_TRIES - 1)) begin
                                up_x    <= 10'(SCREEN_W / 2);
                                up_y    <= 10'(SCREEN_H / 2);
                                visible <= 1'b1;
                                timer   <= '0;
                                state   <= S_ACTIVE;
                            end
                        end
                    end
                    S_ACTIVE: begin
                        if (timer == TW'(LIFETIME - 1)) begin
                            up_x    <= 10'(PARK_X);
                            up_y    <= 10'(PARK_Y);
                            visible <= 1'b0;
                            timer   <= '0;
                            state   <= S_WAIT;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    default: begin
                        up_x    <= 10'(PARK_X);
                        up_y    <= 10'(PARK_Y);
                        visible <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.UpgradeX        = up_x;
    assign bus.UpgradeY        = up_y;
    assign bus.Upgrade_Size    = 10'(UPGRADE_SIZE);
    assign bus.upgrade_visible = visible;
endmodule

// File: tb/tb_upgrade_spawner.sv
// tb/tb_upgrade_spawner.sv - directed and randomized checks of upgrade_spawner against a spawn-rule model
module tb_upgrade_spawner;
    localparam int SPAWN_DELAY = 4;
    localparam int LIFETIME    = 8;
    localparam int NSEQ        = 4096;

    logic frame_clk = 1'b0;
    logic Reset     = 1'b0;
    upgrade_spawner_if bus();

    upgrade_spawner #(
        .SPAWN_DELAY (SPAWN_DELAY),
        .LIFETIME    (LIFETIME)
    ) dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus.master)
    );

    always #5 frame_clk = ~frame_clk;

    int errors = 0;
    int checks = 0;
    int idx    = 0;
    int unsigned seq [NSEQ];
    int bx, by, b2x, b2y, bs;
    int first_x, first_y;

    function automatic int unsigned lfsr_next(input int unsigned v);
        int unsigned fb;
        fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
        return ((v << 1) | fb) & 16'hFFFF;
    endfunction

    function automatic bit near(input int a, input int b, input int r);
        return ((a > b) ? a - b : b - a) <= r;
    endfunction

    // First acceptable candidate from LFSR history starting at frame 'start', or the centre fallback.
    function automatic void predict(input int start, output int x, output int y, output int n);
        int r, cx, cy;
        bit ok;
        r = bs + 4 + 8;
        for (int k = 0; k < 16; k++) begin
            cx = 32 + int'(seq[start + k] & 511);
            cy = 32 + int'((seq[start + k] >> 8) & 255);
            ok = (cx <= 607) && (cy <= 447)
              && !(near(cx, bx, r) && near(cy, by, r))
              && !(near(cx, b2x, r) && near(cy, b2y, r));
            if (ok) begin
                x = cx; y = cy; n = k + 1;
                return;
            end
        end
        x = 320; y = 240; n = 16;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int x, input int y, input int vis);
        chk({tag, ".x"}, 32'(bus.UpgradeX), 32'(x));
        chk({tag, ".y"}, 32'(bus.UpgradeY), 32'(y));
        chk({tag, ".vis"}, 32'(bus.upgrade_visible), 32'(vis));
    endtask

    task automatic tick();
        @(posedge frame_clk);
        #1;
        idx++;
    endtask

    task automatic set_balls(input int x1, input int y1, input int x2, input int y2, input int s);
        bx = x1; by = y1; b2x = x2; b2y = y2; bs = s;
        bus.BallX = 10'(x1); bus.BallY = 10'(y1);
        bus.Ball2X = 10'(x2); bus.Ball2Y = 10'(y2);
        bus.Ball_Size = 10'(s);
    endtask

    task automatic do_reset(input string tag, input int frames);
        Reset = 1'b1;
        #1;
        chk_out({tag, ".async"}, 1000, 1000, 0);
        repeat (frames) begin
            tick();
            chk_out({tag, ".held"}, 1000, 1000, 0);
        end
        Reset = 1'b0;
        idx = 0;
    endtask

    task automatic wait_phase(input string tag);
        repeat (SPAWN_DELAY) begin
            tick();
            chk_out({tag, ".wait"}, 1000, 1000, 0);
        end
    endtask

    task automatic do_spawn(input string tag, output int x, output int y);
        int n;
        predict(idx, x, y, n);
        repeat (n - 1) begin
            tick();
            chk_out({tag, ".pick"}, 1000, 1000, 0);
        end
        tick();
        chk_out({tag, ".spawn"}, x, y, 1);
    endtask

    initial begin
        int x, y, m;
        seq[0] = 32'hACE1;
        for (int i = 1; i < NSEQ; i++) seq[i] = lfsr_next(seq[i - 1]);
        bus.was_collected = 1'b0;
        set_balls(10, 10, 10, 10, 8);
        #2;

        // Scenarios 1-2: reset, delay into PICK, first LFSR-predicted spawn, hold.
        do_reset("s1", 3);
        chk("s1.size", 32'(bus.Upgrade_Size), 32'd4);
        wait_phase("s1");
        do_spawn("s2", first_x, first_y);
        repeat (LIFETIME - 1) begin
            tick();
            chk_out("s2.hold", first_x, first_y, 1);
        end

        // Scenario 3: lifetime expiry, park, respawn from later LFSR history.
        tick();
        chk_out("s3.expire", 1000, 1000, 0);
        wait_phase("s3");
        do_spawn("s3", x, y);

        // Scenario 4: collection three frames into ACTIVE, then terminal.
        repeat (3) begin
            tick();
            chk_out("s4.active", x, y, 1);
        end
        bus.was_collected = 1'b1;
        tick();
        chk_out("s4.collect", 1000, 1000, 0);
        for (int i = 0; i < 1000; i++) begin
            bus.was_collected = 1'($urandom_range(0, 1));
            tick();
            chk_out("s4.terminal", 1000, 1000, 0);
        end
        bus.was_collected = 1'b0;

        // Scenario 5: players cover every candidate, forcing the centre fallback.
        set_balls(288, 160, 288, 160, 300);
        do_reset("s5", 1);
        wait_phase("s5");
        do_spawn("s5", x, y);
        chk("s5.fallback_x", 32'(bus.UpgradeX), 32'd320);
        chk("s5.fallback_y", 32'(bus.UpgradeY), 32'd240);

        // Scenario 6: collect coincides with expiry; then reset reproduces the first spawn.
        repeat (LIFETIME - 1) begin
            tick();
            chk_out("s6.active", 320, 240, 1);
        end
        bus.was_collected = 1'b1;
        tick();
        chk_out("s6.tie", 1000, 1000, 0);
        bus.was_collected = 1'b0;
        repeat (30) begin
            tick();
            chk_out("s6.stay", 1000, 1000, 0);
        end
        set_balls(10, 10, 10, 10, 8);
        #3;
        do_reset("s6.rst", 2);
        wait_phase("s6");
        do_spawn("s6.replay", x, y);
        chk("s6.replay_x", 32'(bus.UpgradeX), 32'(first_x));
        chk("s6.replay_y", 32'(bus.UpgradeY), 32'(first_y));

        // Randomized rounds: random players, expiry/respawn, async reset mid-ACTIVE.
        for (int r = 0; r < 6; r++) begin
            set_balls($urandom_range(0, 639), $urandom_range(0, 479),
                      $urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 120));
            do_reset("rnd.rst", 1);
            wait_phase("rnd");
            do_spawn("rnd", x, y);
            repeat (LIFETIME - 1) begin
                tick();
                chk_out("rnd.hold", x, y, 1);
            end
            tick();
            chk_out("rnd.expire", 1000, 1000, 0);
            set_balls($urandom_range(0, 639), $urandom_range(0, 479),
                      $urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 200));
            wait_phase("rnd2");
            do_spawn("rnd2", x, y);
            m = $urandom_range(0, LIFETIME - 2);
            repeat (m) begin
                tick();
                chk_out("rnd2.hold", x, y, 1);
            end
            #2;
            Reset = 1'b1;
            #1;
            chk_out("rnd.async_park", 1000, 1000, 0);
            Reset = 1'b0;
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
